mesh_flit_source: RTL and testbench

- Credit-based packet generator; drives one router injection channel in the 3x3 mesh verification environment.
- Directly upstream of the router input port; the router delivers to the ejection sink.
- Emits explicit-length packets: head flit plus 1..4 payload flits.
- Tracks per-VC credits returned on flow_ctrl and never overruns the downstream buffer.

---
 rtl/mesh_flit_source_pkg.sv | 45 ++++
 rtl/mesh_flit_source_credit_tracker.sv | 91 +++++++++
 rtl/mesh_flit_source.sv | 179 +++++++++++++++++
 tb/tb_mesh_flit_source.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_flit_source_pkg.sv
// Shared types, layout constants and mesh helpers for the mesh flit source.
package mesh_flit_source_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } src_state_e;

    localparam int MESH_NODES     = 9;
    localparam int DIM_WIDTH      = 2;
    localparam int PKT_ID_WIDTH   = 32;
    // Payload top bits: src dims (4) + packet id (32); the rest is the flit index.
    localparam int PAYLOAD_HDR_W  = 2 * DIM_WIDTH + PKT_ID_WIDTH;

    function automatic int clogb(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic logic [3:0] next_node(input logic [3:0] node);
        return (node == 4'(MESH_NODES - 1)) ? 4'd0 : node + 4'd1;
    endfunction

    // Returns {dim1, dim2} for node = 3*dim1 + dim2.
    function automatic logic [3:0] node_dims(input logic [3:0] node);
        logic [3:0] dims;
        case (node)
            4'd0:    dims = {2'd0, 2'd0};
            4'd1:    dims = {2'd0, 2'd1};
            4'd2:    dims = {2'd0, 2'd2};
            4'd3:    dims = {2'd1, 2'd0};
            4'd4:    dims = {2'd1, 2'd1};
            4'd5:    dims = {2'd1, 2'd2};
            4'd6:    dims = {2'd2, 2'd0};
            4'd7:    dims = {2'd2, 2'd1};
            4'd8:    dims = {2'd2, 2'd2};
            default: dims = 4'd0;
        endcase
        return dims;
    endfunction

endpackage

// File: rtl/mesh_flit_source_credit_tracker.sv
// Per-VC downstream credit counters with saturation error and round-robin VC pick.
module src_credit_tracker
    import mesh_flit_source_pkg::*;
#(
    parameter int num_vcs = 8,
    parameter int credits = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       credit_valid_i,
    input  logic [clogb(num_vcs)-1:0]  credit_vc_i,
    input  logic                       debit_valid_i,
    input  logic [clogb(num_vcs)-1:0]  debit_vc_i,
    input  logic                       head_sent_i,
    output logic [num_vcs-1:0]         credit_nz_o,
    output logic                       any_credit_o,
    output logic [clogb(num_vcs)-1:0]  grant_vc_o,
    output logic                       error_o
);

    localparam int VC_W  = clogb(num_vcs);
    localparam int CNT_W = clogb(credits + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(credits);

    logic [CNT_W-1:0] count_q [num_vcs];
    logic [CNT_W-1:0] count_d [num_vcs];
    logic [num_vcs-1:0] inc_vec, dec_vec, credit_nz;
    logic               error_q, error_d;
    logic [VC_W-1:0]    rr_q, rr_d, grant;
    logic [VC_W:0]      cand;
    logic               found;

    always_comb begin
        for (int v = 0; v < num_vcs; v++) begin
            inc_vec[v]   = credit_valid_i && (credit_vc_i == VC_W'(v));
            dec_vec[v]   = debit_valid_i && (debit_vc_i == VC_W'(v));
            credit_nz[v] = (count_q[v] != '0);
        end
    end

    // A return and a send on the same VC cancel, so only a lone return can overflow.
    always_comb begin
        error_d = error_q;
        for (int v = 0; v < num_vcs; v++) begin
            count_d[v] = count_q[v];
            if (inc_vec[v] && !dec_vec[v]) begin
                if (count_q[v] == CNT_MAX) error_d = 1'b1;
                else                       count_d[v] = count_q[v] + CNT_W'(1);
            end else if (dec_vec[v] && !inc_vec[v] && count_q[v] != '0) begin
                count_d[v] = count_q[v] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < num_vcs; i++) begin
            cand = {1'b0, rr_q} + (VC_W+1)'(i);
            if (cand >= (VC_W+1)'(num_vcs)) cand = cand - (VC_W+1)'(num_vcs);
            if (!found && credit_nz[cand[VC_W-1:0]]) begin
                found = 1'b1;
                grant = cand[VC_W-1:0];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (head_sent_i) rr_d = (grant == VC_W'(num_vcs - 1)) ? '0 : grant + VC_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < num_vcs; v++) count_q[v] <= CNT_MAX;
            error_q <= 1'b0;
            rr_q    <= '0;
        end else begin
            for (int v = 0; v < num_vcs; v++) count_q[v] <= count_d[v];
            error_q <= error_d;
            rr_q    <= rr_d;
        end
    end

    assign credit_nz_o  = credit_nz;
    assign any_credit_o = |credit_nz;
    assign grant_vc_o   = grant;
    assign error_o      = error_q;

endmodule

// File: rtl/mesh_flit_source.sv
// Credit-based packet generator driving one mesh router injection channel.
// state | meaning
// IDLE  | waiting for enable, injection slot and any VC credit
// HEAD  | sending head flit on round-robin VC, locking that VC
// BODY  | sending payload flits on locked VC, stalling without credit
module mesh_flit_source
    import mesh_flit_source_pkg::*;
#(
    parameter int          num_vcs            = 8,
    parameter int          buffer_size        = 64,
    parameter int          flit_data_width    = 64,
    parameter int          route_info_width   = 14,
    parameter int          max_payload_length = 4,
    parameter int          min_payload_length = 1,
    parameter int          src_dim1           = 0,
    parameter int          src_dim2           = 0,
    parameter int          num_packets        = 16,
    parameter int          inject_threshold   = 128,
    parameter logic [15:0] lfsr_seed          = 16'hACE1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        enable,
    input  logic [clogb(num_vcs):0]                     flow_ctrl,
    output logic [clogb(num_vcs)+flit_data_width+2:0]   channel,
    output logic [31:0]                                 pkt_count,
    output logic                                        done,
    output logic                                        error
);

    localparam int VC_W     = clogb(num_vcs);
    localparam int CREDITS  = buffer_size / num_vcs;
    localparam int LEN_SPAN = max_payload_length - min_payload_length + 1;
    localparam int LCODE_W  = (clogb(LEN_SPAN) < 1) ? 1 : clogb(LEN_SPAN);
    localparam int LEN_W    = clogb(max_payload_length + 1);
    localparam int IDX_W    = flit_data_width - PAYLOAD_HDR_W;
    localparam int CH_W     = VC_W + flit_data_width + 3;
    localparam logic [3:0] OWN_NODE = 4'(3 * src_dim1 + src_dim2);

    src_state_e           state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [31:0]          pkt_count_q, pkt_count_d;
    logic                 done_q, done_d;
    logic [VC_W-1:0]      locked_vc_q, locked_vc_d;
    logic [LEN_W-1:0]     flit_idx_q, flit_idx_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LCODE_W-1:0]   len_code_q, len_code_d;
    logic [3:0]           dest_q, dest_d;
    logic [CH_W-1:0]      channel_q, channel_d;

    logic [num_vcs-1:0]   credit_nz;
    logic                 any_credit;
    logic [VC_W-1:0]      grant_vc;
    logic                 credit_error;

    logic                 send_valid, send_head, head_sent, link_d, inject_ok;
    logic [VC_W-1:0]      send_vc;
    logic [flit_data_width-1:0] send_data, head_data, payload_data;
    logic [3:0]           head_node, head_dims;

    assign lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign inject_ok = ({25'd0, lfsr_q[6:0]} < 32'(inject_threshold));

    // The destination walk never targets this source's own node.
    assign head_node = (dest_q == OWN_NODE) ? next_node(dest_q) : dest_q;
    assign head_dims = node_dims(head_node);

    always_comb begin
        head_data = '0;
        head_data[DIM_WIDTH-1:0]             = head_dims[3:2];
        head_data[2*DIM_WIDTH-1:DIM_WIDTH]   = head_dims[1:0];
        head_data[route_info_width +: LCODE_W] = len_code_q;
    end

    assign payload_data = {2'(src_dim2), 2'(src_dim1), pkt_count_q, IDX_W'(flit_idx_q)};

    always_comb begin
        state_d     = state_q;
        pkt_count_d = pkt_count_q;
        done_d      = done_q;
        locked_vc_d = locked_vc_q;
        flit_idx_d  = flit_idx_q;
        len_d       = len_q;
        len_code_d  = len_code_q;
        dest_d      = dest_q;
        send_valid  = 1'b0;
        send_head   = 1'b0;
        send_vc     = '0;
        send_data   = '0;
        head_sent   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && !done_q && inject_ok && any_credit) state_d = ST_HEAD;
            end
            ST_HEAD: begin
                if (any_credit) begin
                    send_valid  = 1'b1;
                    send_head   = 1'b1;
                    send_vc     = grant_vc;
                    send_data   = head_data;
                    head_sent   = 1'b1;
                    locked_vc_d = grant_vc;
                    flit_idx_d  = LEN_W'(1);
                    len_d       = LEN_W'(min_payload_length) + LEN_W'(len_code_q);
                    dest_d      = next_node(head_node);
                    state_d     = ST_BODY;
                end
            end
            ST_BODY: begin
                if (credit_nz[locked_vc_q]) begin
                    send_valid = 1'b1;
                    send_vc    = locked_vc_q;
                    send_data  = payload_data;
                    if (flit_idx_q == len_q) begin
                        state_d     = ST_IDLE;
                        pkt_count_d = pkt_count_q + 32'd1;
                        len_code_d  = (len_code_q == LCODE_W'(LEN_SPAN - 1)) ? '0
                                                                             : len_code_q + LCODE_W'(1);
                        if (num_packets != 0 && pkt_count_d == 32'(num_packets)) done_d = 1'b1;
                    end else begin
                        flit_idx_d = flit_idx_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        link_d    = (state_d != ST_IDLE) || send_valid;
        channel_d = {link_d, send_valid, send_vc, send_head, send_data};
    end

    src_credit_tracker #(
        .num_vcs (num_vcs),
        .credits (CREDITS)
    ) u_credit (
        .clk            (clk),
        .rst_n          (reset),
        .credit_valid_i (flow_ctrl[VC_W]),
        .credit_vc_i    (flow_ctrl[VC_W-1:0]),
        .debit_valid_i  (send_valid),
        .debit_vc_i     (send_vc),
        .head_sent_i    (head_sent),
        .credit_nz_o    (credit_nz),
        .any_credit_o   (any_credit),
        .grant_vc_o     (grant_vc),
        .error_o        (credit_error)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= lfsr_seed;
            pkt_count_q <= '0;
            done_q      <= 1'b0;
            locked_vc_q <= '0;
            flit_idx_q  <= '0;
            len_q       <= '0;
            len_code_q  <= '0;
            dest_q      <= '0;
            channel_q   <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            pkt_count_q <= pkt_count_d;
            done_q      <= done_d;
            locked_vc_q <= locked_vc_d;
            flit_idx_q  <= flit_idx_d;
            len_q       <= len_d;
            len_code_q  <= len_code_d;
            dest_q      <= dest_d;
            channel_q   <= channel_d;
        end
    end

    assign channel   = channel_q;
    assign pkt_count = pkt_count_q;
    assign done      = done_q;
    assign error     = credit_error;

endmodule

// File: tb/tb_mesh_flit_source.sv
// Directed and randomized bench for mesh_flit_source with a packet-level scoreboard.
module tb_mesh_flit_source;

    localparam int NV   = 8;
    localparam int CR   = 8;
    localparam int NPK  = 16;
    localparam int SD1  = 1;
    localparam int SD2  = 2;
    localparam int OWN  = 3 * SD1 + SD2;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [3:0]  flow_ctrl;
    logic [69:0] channel;
    logic [31:0] pkt_count;
    logic        done, error;

    always #5 clk = ~clk;

    mesh_flit_source #(
        .src_dim1 (SD1),
        .src_dim2 (SD2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flow_ctrl (flow_ctrl),
        .channel   (channel),
        .pkt_count (pkt_count),
        .done      (done),
        .error     (error)
    );

    wire        ch_link = channel[69];
    wire        ch_fv   = channel[68];
    wire [2:0]  ch_vc   = channel[67:65];
    wire        ch_head = channel[64];
    wire [63:0] ch_data = channel[63:0];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: credits, rr pointer, destination walk, packet progress.
    int cred [NV];
    int rr_m, dest_m, k_m, locked_m, idx_m, len_m;
    bit in_pkt, err_m, prev_en;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) cred[i] = CR;
        rr_m = 0; dest_m = 0; k_m = 0; locked_m = 0; idx_m = 0; len_m = 0;
        in_pkt = 0; err_m = 0; prev_en = 0;
    endtask

    function automatic logic [63:0] exp_head(input int node, input int code);
        return 64'(node / 3) | (64'(node % 3) << 2) | (64'(code) << 14);
    endfunction

    function automatic logic [63:0] exp_payload(input int k, input int idx);
        return (64'(SD2) << 62) | (64'(SD1) << 60) | (64'(k) << 28) | 64'(idx);
    endfunction

    task automatic observe(input bit fcv, input int fcvc);
        int pick;
        if (ch_fv) begin
            chk("link_on_flit", ch_link, 1);
            if (ch_head) begin
                chk("head_while_busy", in_pkt, 0);
                chk("head_enable", prev_en, 1);
                chk("head_after_done", k_m < NPK, 1);
                pick = -1;
                for (int i = 0; i < NV; i++)
                    if (pick < 0 && cred[(rr_m + i) % NV] > 0) pick = (rr_m + i) % NV;
                chk("head_vc", ch_vc, pick);
                if (dest_m == OWN) dest_m = (dest_m + 1) % 9;
                len_m = 1 + k_m % 4;
                chk("head_data", ch_data, exp_head(dest_m, len_m - 1));
                dest_m   = (dest_m + 1) % 9;
                rr_m     = (int'(ch_vc) + 1) % NV;
                locked_m = ch_vc;
                idx_m    = 0;
                in_pkt   = 1;
            end else begin
                chk("payload_in_pkt", in_pkt, 1);
                chk("payload_vc", ch_vc, locked_m);
                idx_m++;
                chk("payload_data", ch_data, exp_payload(k_m, idx_m));
                if (idx_m >= len_m) begin
                    in_pkt = 0;
                    k_m++;
                end
            end
            chk("credit_available", cred[ch_vc] > 0, 1);
            cred[ch_vc]--;
        end else if (in_pkt) begin
            chk("link_in_stall", ch_link, 1);
        end
        if (fcv) begin
            if (cred[fcvc] >= CR) err_m = 1;
            else                  cred[fcvc]++;
        end
        chk("pkt_count", pkt_count, k_m);
        chk("done", done, k_m >= NPK);
        chk("error", error, err_m);
    endtask

    task automatic step();
        bit fcv;
        int fcvc;
        bit en_now;
        fcv    = flow_ctrl[3];
        fcvc   = int'(flow_ctrl[2:0]);
        en_now = enable;
        @(posedge clk);
        #1;
        observe(fcv, fcvc);
        prev_en = en_now;
    endtask

    task automatic drive_random_credit();
        int v;
        flow_ctrl = 4'd0;
        if ($urandom_range(0, 9) < 6) begin
            if (in_pkt && $urandom_range(0, 1) == 1) v = locked_m;
            else                                     v = int'($urandom_range(0, NV - 1));
            // At full credit only return on the VC being debited this edge.
            if (cred[v] < CR || (in_pkt && v == locked_m && cred[v] > 0))
                flow_ctrl = {1'b1, 3'(v)};
        end
    endtask

    task automatic drive_safe_credit();
        int v;
        flow_ctrl = 4'd0;
        v = int'($urandom_range(0, NV - 1));
        if (cred[v] < CR) flow_ctrl = {1'b1, 3'(v)};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fv_cnt, link_cnt;
        bit seen;
        reset = 1'b0; enable = 1'b0; flow_ctrl = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_channel", channel, 0);
        chk("reset_pkt_count", pkt_count, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);

        // Extra credit on a full VC sets a sticky error.
        reset = 1'b1;
        flow_ctrl = {1'b1, 3'd5};
        step();
        flow_ctrl = 4'd0;
        repeat (4) step();
        chk("error_sticky", error, 1);
        reset = 1'b0;
        #1;
        chk("error_cleared", error, 0);
        chk("reset_channel2", channel, 0);
        model_reset();

        // First packet timing, no credit returns until the body stalls.
        enable = 1'b1;
        reset  = 1'b1;
        step();
        chk("first_idle", ch_fv, 0);
        step();
        chk("first_head", {ch_fv, ch_head, ch_vc}, {1'b1, 1'b1, 3'd0});
        chk("first_head_data", ch_data, 64'd0);
        step();
        chk("first_payload", {ch_fv, ch_head, ch_data}, {1'b1, 1'b0, exp_payload(0, 1)});
        chk("first_pkt_count", pkt_count, 1);
        for (int c = 0; c < 400 && !(in_pkt && cred[locked_m] == 0); c++) step();
        chk("stall_pkt_count", pkt_count, 11);
        chk("stall_vc", {ch_fv, ch_vc}, {1'b1, 3'd3});
        step();
        chk("stall_idle", {ch_link, ch_fv}, 2'b10);
        for (int r = 0; r < 2; r++) begin
            flow_ctrl = {1'b1, 3'd3};
            step();
            flow_ctrl = 4'd0;
            chk("release_wait", ch_fv, 0);
            step();
            chk("release_one", {ch_fv, ch_head, ch_vc}, {1'b1, 1'b0, 3'd3});
        end
        chk("stall_done_count", pkt_count, 12);

        // Reset during a packet aborts it at once.
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            step();
            seen = ch_fv && ch_head;
        end
        chk("abort_head_seen", seen, 1);
        reset = 1'b0;
        #1;
        chk("abort_channel", channel, 0);
        chk("abort_pkt_count", pkt_count, 0);
        model_reset();
        #2;

        // Random credit returns and enable until the packet quota is met.
        reset = 1'b1;
        for (int c = 0; c < 4000 && !(k_m >= NPK && !in_pkt); c++) begin
            enable = ($urandom_range(0, 7) != 0);
            drive_random_credit();
            step();
        end
        flow_ctrl = 4'd0;
        chk("done_reached", {done, pkt_count}, {1'b1, 32'd16});

        enable = 1'b1;
        fv_cnt = 0;
        link_cnt = 0;
        for (int c = 0; c < 100; c++) begin
            drive_safe_credit();
            step();
            if (ch_fv)   fv_cnt++;
            if (ch_link) link_cnt++;
        end
        flow_ctrl = 4'd0;
        chk("quiet_after_done", fv_cnt, 0);
        chk("link_quiet_after_done", link_cnt, 0);
        chk("done_held", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
